// File: rtl/uart_bps_gen_if.sv
// Bit-timing bus for uart_bps_gen: run/baud controls in, strobes and frame status out.
// The master drives the controls; the slave (the generator) drives the timing outputs.
interface uart_bps_gen_if;
    logic       Count_Sig;
    logic [1:0] Baud_Sel;
    logic       BPS_CLK;
    logic       Bit_End;
    logic       Ovs_Tick;
    logic [3:0] Bit_Idx;
    logic       Frame_Done;
    logic       Busy;

    modport master (
        output Count_Sig,
        output Baud_Sel,
        input  BPS_CLK,
        input  Bit_End,
        input  Ovs_Tick,
        input  Bit_Idx,
        input  Frame_Done,
        input  Busy
    );

    modport slave (
        input  Count_Sig,
        input  Baud_Sel,
        output BPS_CLK,
        output Bit_End,
        output Ovs_Tick,
        output Bit_Idx,
        output Frame_Done,
        output Busy
    );
endinterface

// File: rtl/uart_bps_gen.sv
// UART bit-period generator: mid-bit sample strobe, bit-end strobe, oversample ticks
// and frame sequencing over FRAME_BITS bit periods at one of four selectable divisors.
module uart_bps_gen #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned DIV0       = 5208,
    parameter int unsigned DIV1       = 2604,
    parameter int unsigned DIV2       = 1736,
    parameter int unsigned DIV3       = 434,
    parameter int unsigned FRAME_BITS = 10,
    parameter int unsigned OVS_LOG2   = 4
) (
    input  logic          CLK,
    input  logic          RSTn,
    uart_bps_gen_if.slave bps_if
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0]  Div0     = CNT_W'(DIV0);
    localparam logic [CNT_W-1:0]  Div1     = CNT_W'(DIV1);
    localparam logic [CNT_W-1:0]  Div2     = CNT_W'(DIV2);
    localparam logic [CNT_W-1:0]  Div3     = CNT_W'(DIV3);
    localparam logic [3:0]        LastBit  = 4'(FRAME_BITS - 1);
    localparam logic [OVS_LOG2:0] OvsTicks = (OVS_LOG2 + 1)'(1 << OVS_LOG2);

    state_e              r_state;
    logic [CNT_W-1:0]    r_div;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_ovs_cnt;
    logic [OVS_LOG2:0]   r_ovs_num;
    logic [3:0]          r_bit_idx;
    logic                r_frame_done;

    state_e              w_state_d;
    logic [CNT_W-1:0]    w_div_d;
    logic [CNT_W-1:0]    w_count_d;
    logic [CNT_W-1:0]    w_ovs_cnt_d;
    logic [OVS_LOG2:0]   w_ovs_num_d;
    logic [3:0]          w_bit_idx_d;
    logic                w_frame_done_d;

    logic [CNT_W-1:0]    w_div_sel;
    logic [CNT_W-1:0]    w_ovs_div;
    logic                w_run;
    logic                w_bit_last;
    logic                w_ovs_last;
    logic                w_ovs_tick;

    always_comb begin
        w_div_sel = Div0;
        unique case (bps_if.Baud_Sel)
            2'd0: w_div_sel = Div0;
            2'd1: w_div_sel = Div1;
            2'd2: w_div_sel = Div2;
            2'd3: w_div_sel = Div3;
        endcase
    end

    assign w_run      = (r_state == StRun);
    assign w_ovs_div  = r_div >> OVS_LOG2;
    assign w_bit_last = (r_count == r_div - CNT_W'(1));
    assign w_ovs_last = (r_ovs_cnt == w_ovs_div - CNT_W'(1));
    // Ticks stop once the full count is reached, so remainder cycles of a bit stay quiet.
    assign w_ovs_tick = w_run && w_ovs_last && (r_ovs_num < OvsTicks);

    always_comb begin
        w_state_d      = r_state;
        w_div_d        = r_div;
        w_count_d      = '0;
        w_ovs_cnt_d    = '0;
        w_ovs_num_d    = '0;
        w_bit_idx_d    = '0;
        w_frame_done_d = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_div_d = w_div_sel;
                if (bps_if.Count_Sig) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                if (!bps_if.Count_Sig) begin
                    w_state_d = StIdle;
                end else if (w_bit_last) begin
                    if (r_bit_idx == LastBit) begin
                        w_state_d      = StDone;
                        w_frame_done_d = 1'b1;
                    end else begin
                        w_bit_idx_d = r_bit_idx + 4'd1;
                    end
                end else begin
                    w_count_d   = r_count + CNT_W'(1);
                    w_bit_idx_d = r_bit_idx;
                    if (w_ovs_last) begin
                        w_ovs_num_d = w_ovs_tick ? r_ovs_num + 1'b1 : r_ovs_num;
                    end else begin
                        w_ovs_cnt_d = r_ovs_cnt + CNT_W'(1);
                        w_ovs_num_d = r_ovs_num;
                    end
                end
            end
            StDone: begin
                if (!bps_if.Count_Sig) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state      <= StIdle;
            r_div        <= Div0;
            r_count      <= '0;
            r_ovs_cnt    <= '0;
            r_ovs_num    <= '0;
            r_bit_idx    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_div        <= w_div_d;
            r_count      <= w_count_d;
            r_ovs_cnt    <= w_ovs_cnt_d;
            r_ovs_num    <= w_ovs_num_d;
            r_bit_idx    <= w_bit_idx_d;
            r_frame_done <= w_frame_done_d;
        end
    end

    assign bps_if.BPS_CLK    = w_run && (r_count == (r_div >> 1));
    assign bps_if.Bit_End    = w_run && w_bit_last;
    assign bps_if.Ovs_Tick   = w_ovs_tick;
    assign bps_if.Bit_Idx    = r_bit_idx;
    assign bps_if.Frame_Done = r_frame_done;
    assign bps_if.Busy       = w_run;

endmodule

// File: tb/tb_uart_bps_gen.sv
// Randomised self-checking bench for uart_bps_gen; expected outputs come from a per-cycle
// model computed from the frame offset and divisor with plain arithmetic.
module tb_uart_bps_gen;

    localparam int FRAME_BITS = 10;
    localparam int OVS_LOG2   = 2;

    logic CLK;
    logic RSTn;
    int   n_checks;
    int   n_fail;
    int   divs [4];

    uart_bps_gen_if bus ();

    uart_bps_gen #(
        .CNT_W      (16),
        .DIV0       (32),
        .DIV1       (34),
        .DIV2       (40),
        .DIV3       (48),
        .FRAME_BITS (FRAME_BITS),
        .OVS_LOG2   (OVS_LOG2)
    ) dut (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .bps_if (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // {Busy, BPS_CLK, Bit_End, Ovs_Tick, Frame_Done, Bit_Idx}
    function automatic logic [8:0] observe();
        return {bus.Busy, bus.BPS_CLK, bus.Bit_End, bus.Ovs_Tick, bus.Frame_Done, bus.Bit_Idx};
    endfunction

    // Expected outputs k cycles after the first RUN cycle of a frame with divisor d.
    function automatic logic [8:0] model(int k, int d);
        int   od;
        int   c;
        logic bps;
        logic bend;
        logic ovs;
        od = d >> OVS_LOG2;
        if (k < FRAME_BITS * d) begin
            c    = k % d;
            bps  = (c == d / 2);
            bend = (c == d - 1);
            ovs  = ((c + 1) % od == 0) && ((c + 1) / od <= (1 << OVS_LOG2));
            return {1'b1, bps, bend, ovs, 1'b0, 4'(k / d)};
        end
        if (k == FRAME_BITS * d) return 9'b0_0000_1_0000;
        return 9'd0;
    endfunction

    task automatic test_reset();
        logic [8:0] got;
        RSTn = 1'b0;
        bus.Count_Sig = 1'b0;
        bus.Baud_Sel  = 2'd0;
        #12;
        got = observe();
        n_checks++;
        if (got !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_state got=%b exp=%b", got, 9'd0);
        end
        @(negedge CLK);
        RSTn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            got = observe();
            n_checks++;
            if (got !== 9'd0) begin
                n_fail++;
                $display("FAIL idle_after_reset cyc=%0d got=%b exp=%b", i, got, 9'd0);
            end
        end
    endtask

    task automatic test_frame_sel0();
        logic [8:0] got;
        logic [8:0] exp;
        int         n_bps;
        int         n_done;
        n_bps  = 0;
        n_done = 0;
        bus.Baud_Sel  = 2'd0;
        bus.Count_Sig = 1'b1;
        tick();
        for (int k = 0; k < FRAME_BITS * 32 + 6; k++) begin
            got = observe();
            exp = model(k, 32);
            n_bps  += int'(got[7]);
            n_done += int'(got[4]);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL frame_sel0 k=%0d got=%b exp=%b", k, got, exp);
            end
            tick();
        end
        n_checks++;
        if (n_bps != FRAME_BITS || n_done != 1) begin
            n_fail++;
            $display("FAIL frame_sel0_counts bps=%0d done=%0d exp bps=%0d done=1",
                     n_bps, n_done, FRAME_BITS);
        end
        bus.Count_Sig = 1'b0;
        tick();
    endtask

    task automatic test_ovs_sel1();
        logic [8:0] got;
        logic [8:0] exp;
        int         n_ovs;
        n_ovs = 0;
        bus.Baud_Sel  = 2'd1;
        bus.Count_Sig = 1'b1;
        tick();
        for (int k = 0; k < FRAME_BITS * 34 + 3; k++) begin
            got = observe();
            exp = model(k, 34);
            n_ovs += int'(got[5]);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL ovs_sel1 k=%0d got=%b exp=%b", k, got, exp);
            end
            tick();
        end
        n_checks++;
        if (n_ovs != FRAME_BITS * 4) begin
            n_fail++;
            $display("FAIL ovs_sel1_tick_count got=%0d exp=%0d", n_ovs, FRAME_BITS * 4);
        end
        bus.Count_Sig = 1'b0;
        tick();
    endtask

    task automatic test_baud_change();
        logic [8:0] got;
        logic [8:0] exp;
        bus.Baud_Sel  = 2'd0;
        bus.Count_Sig = 1'b1;
        tick();
        for (int k = 0; k <= FRAME_BITS * 32 + 2; k++) begin
            got = observe();
            exp = model(k, 32);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL baud_change_hold k=%0d got=%b exp=%b", k, got, exp);
            end
            if (k == 3 * 32) bus.Baud_Sel = 2'd1;
            tick();
        end
        bus.Count_Sig = 1'b0;
        tick();
        bus.Count_Sig = 1'b1;
        tick();
        for (int k = 0; k <= FRAME_BITS * 34 + 1; k++) begin
            got = observe();
            exp = model(k, 34);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL baud_change_new k=%0d got=%b exp=%b", k, got, exp);
            end
            tick();
        end
        bus.Count_Sig = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        logic [8:0] got;
        logic [8:0] exp;
        bus.Baud_Sel  = 2'd0;
        bus.Count_Sig = 1'b1;
        tick();
        for (int k = 0; k <= 5 * 32 + 10; k++) begin
            got = observe();
            exp = model(k, 32);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL abort_pre k=%0d got=%b exp=%b", k, got, exp);
            end
            if (k < 5 * 32 + 10) tick();
        end
        bus.Count_Sig = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            got = observe();
            n_checks++;
            if (got !== 9'd0) begin
                n_fail++;
                $display("FAIL abort_idle cyc=%0d got=%b exp=%b", i, got, 9'd0);
            end
        end
        bus.Count_Sig = 1'b1;
        tick();
        for (int k = 0; k <= FRAME_BITS * 32 + 1; k++) begin
            got = observe();
            exp = model(k, 32);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL abort_restart k=%0d got=%b exp=%b", k, got, exp);
            end
            tick();
        end
        bus.Count_Sig = 1'b0;
        tick();
    endtask

    task automatic test_done_hold();
        logic [8:0] got;
        logic [8:0] exp;
        bus.Baud_Sel  = 2'd0;
        bus.Count_Sig = 1'b1;
        tick();
        for (int k = 0; k <= FRAME_BITS * 32 + 100; k++) begin
            got = observe();
            exp = model(k, 32);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL done_hold k=%0d got=%b exp=%b", k, got, exp);
            end
            tick();
        end
        bus.Count_Sig = 1'b0;
        tick();
        got = observe();
        n_checks++;
        if (got !== 9'd0) begin
            n_fail++;
            $display("FAIL done_hold_idle got=%b exp=%b", got, 9'd0);
        end
        bus.Count_Sig = 1'b1;
        tick();
        for (int k = 0; k <= FRAME_BITS * 32 + 1; k++) begin
            got = observe();
            exp = model(k, 32);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL done_hold_rerun k=%0d got=%b exp=%b", k, got, exp);
            end
            tick();
        end
        bus.Count_Sig = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic [8:0] got;
        logic [8:0] exp;
        int         stop_k;
        stop_k = int'($urandom_range(300, 40));
        bus.Baud_Sel  = 2'd0;
        bus.Count_Sig = 1'b1;
        tick();
        for (int k = 0; k < stop_k; k++) tick();
        #2;
        RSTn = 1'b0;
        #1;
        got = observe();
        n_checks++;
        if (got !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_mid_run_async got=%b exp=%b", got, 9'd0);
        end
        bus.Baud_Sel = 2'd1;
        tick();
        RSTn = 1'b1;
        tick();
        for (int k = 0; k <= FRAME_BITS * 34 + 1; k++) begin
            got = observe();
            exp = model(k, 34);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_run_after k=%0d got=%b exp=%b", k, got, exp);
            end
            tick();
        end
        bus.Count_Sig = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [8:0] got;
        logic [8:0] exp;
        int         sel;
        int         d;
        int         stop_k;
        for (int n = 0; n < 6; n++) begin
            sel = int'($urandom_range(3, 0));
            d   = divs[sel];
            stop_k = int'($urandom_range(FRAME_BITS * d + 20, 5));
            bus.Baud_Sel  = 2'(sel);
            bus.Count_Sig = 1'b1;
            tick();
            for (int k = 0; k <= stop_k; k++) begin
                got = observe();
                exp = model(k, d);
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL random n=%0d sel=%0d k=%0d got=%b exp=%b",
                             n, sel, k, got, exp);
                end
                if (k < stop_k) begin
                    if ($urandom_range(15, 0) == 0) bus.Baud_Sel = 2'($urandom_range(3, 0));
                    tick();
                end
            end
            bus.Count_Sig = 1'b0;
            tick();
            got = observe();
            n_checks++;
            if (got !== 9'd0) begin
                n_fail++;
                $display("FAIL random_idle n=%0d got=%b exp=%b", n, got, 9'd0);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        divs[0]  = 32;
        divs[1]  = 34;
        divs[2]  = 40;
        divs[3]  = 48;
        test_reset();
        test_frame_sel0();
        test_ovs_sel1();
        test_baud_change();
        test_abort();
        test_done_hold();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
